mor1kx_execute_ctrl_gen: RTL

Parametrised execute-to-control pipeline stage for the cappuccino pipeline. It generalises execute-stage completion tracking to NUM_UNITS multi-cycle units with one-hot selection and latches single-cycle done pulses. A per-instruction watchdog raises a timeout exception. Results, PC, opcode and exception vector pass through a valid/ready output register into the control stage. The block sits between the execute units (ALU/LSU/MUL/DIV) and the control/SPR stage.

---
 rtl/mor1kx_execute_ctrl_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mor1kx_execute_ctrl_gen.sv
// Execute-to-control stage: tracks completion of NUM_UNITS multi-cycle units,
// runs a per-instruction timeout watchdog and registers results for control.
module mor1kx_execute_ctrl_gen #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC = 32'h00000100,
  parameter int NUM_UNITS = 4,
  parameter int EXCEPT_WIDTH = 7,
  parameter int OPC_WIDTH = 6,
  parameter logic [OPC_WIDTH-1:0] OPC_NOP = 6'h05,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic execute_valid_i,
  output logic execute_ready_o,
  output logic execute_waiting_o,
  input  logic [NUM_UNITS-1:0] unit_sel_i,
  input  logic [NUM_UNITS-1:0] unit_done_i,
  input  logic [NUM_UNITS*OPTION_OPERAND_WIDTH-1:0] unit_result_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] base_result_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pc_i,
  input  logic [OPC_WIDTH-1:0] opc_i,
  input  logic [EXCEPT_WIDTH-1:0] except_i,
  input  logic ctrl_ready_i,
  output logic ctrl_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ctrl_result_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ctrl_pc_o,
  output logic [OPC_WIDTH-1:0] ctrl_opc_o,
  output logic [EXCEPT_WIDTH:0] ctrl_except_o,
  output logic ctrl_except_any_o
);

  localparam int W = OPTION_OPERAND_WIDTH;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BLOCKED
  } state_t;

  state_t state;
  state_t state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_nxt;
  logic done_latch;
  logic latch_nxt;

  logic sel_none;
  logic done_sel;
  logic [W-1:0] res_sel;
  logic timeout_hit;
  logic done_seen;
  logic complete;
  logic out_free;
  logic xfer;

  // Descending scan so the lowest selected unit wins.
  always_comb begin
    done_sel = 1'b0;
    res_sel = '0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (unit_sel_i[k]) begin
        done_sel = unit_done_i[k];
        res_sel = unit_result_i[k*W +: W];
      end
    end
  end

  assign sel_none = ~|unit_sel_i;
  assign timeout_hit = wait_cnt == CNT_MAX;
  assign done_seen = !sel_none & (done_sel | done_latch);
  assign complete = execute_valid_i &
                    (sel_none | done_seen | timeout_hit);
  assign out_free = !ctrl_valid_o | ctrl_ready_i;
  assign xfer = complete & out_free & !flush_i;

  assign execute_ready_o = xfer;
  assign execute_waiting_o = execute_valid_i & !complete;
  assign ctrl_except_any_o = ctrl_valid_o & (|ctrl_except_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      done_latch <= 1'b0;
    end else begin
      state <= state_nxt;
      wait_cnt <= cnt_nxt;
      done_latch <= latch_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt = wait_cnt;
    latch_nxt = done_latch;
    if (flush_i) begin
      state_nxt = IDLE;
      cnt_nxt = '0;
      latch_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (execute_valid_i & !xfer)
            state_nxt = complete ? BLOCKED : WAIT;
        end
        WAIT: begin
          if (xfer)
            state_nxt = IDLE;
          else if (complete)
            state_nxt = BLOCKED;
        end
        BLOCKED: begin
          if (xfer)
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
      if (xfer) begin
        cnt_nxt = '0;
        latch_nxt = 1'b0;
      end else begin
        if (state == WAIT && !complete && !timeout_hit)
          cnt_nxt = wait_cnt + 1'b1;
        if (execute_valid_i & !sel_none & done_sel)
          latch_nxt = 1'b1;
      end
    end
  end

  // Result and PC survive a flush; only the qualifying fields are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_valid_o <= 1'b0;
      ctrl_result_o <= '0;
      ctrl_pc_o <= OPTION_RESET_PC;
      ctrl_opc_o <= OPC_NOP;
      ctrl_except_o <= '0;
    end else if (flush_i) begin
      ctrl_valid_o <= 1'b0;
      ctrl_opc_o <= OPC_NOP;
      ctrl_except_o <= '0;
    end else if (xfer) begin
      ctrl_valid_o <= 1'b1;
      ctrl_result_o <= (sel_none | timeout_hit) ? base_result_i : res_sel;
      ctrl_pc_o <= pc_i;
      ctrl_opc_o <= opc_i;
      ctrl_except_o <= {timeout_hit, except_i};
    end else if (ctrl_ready_i) begin
      ctrl_valid_o <= 1'b0;
    end
  end

endmodule
